// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute stage: default datapath widths, ALU
// operation encodings, FSM state encoding and the writeback control bundle.
// No ports (package).
// ---------------------------------------------------------------------------
package exec_pkg;

   localparam int EXEC_DATA_W  = 32;
   localparam int EXEC_SHAMT_W = 5;
   localparam int REG_ADDR_W   = 5;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_ORR   = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_PASSB = 4'b0111;
   localparam logic [3:0] OP_LSL   = 4'b1000;
   localparam logic [3:0] OP_LSR   = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_CBZ   = 4'b1011;
   localparam logic [3:0] OP_CBNZ  = 4'b1100;
   localparam logic [3:0] OP_B     = 4'b1101;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_MUL_BUSY = 1'b1
   } exec_state_e;

   // Writeback/memory control carried alongside the result.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] write_reg;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
   } wb_ctrl_t;

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == OP_MUL);
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ---------------------------------------------------------------------------
// execute_stage_if
// Bundles the upstream operand handshake, the downstream result handshake,
// the flush input and a state debug signal of the execute stage.
//   master modport : producer/consumer side (drives operands, outReady, flush)
//   slave  modport : the execute stage itself
// Handshake rule (both sides): a bundle transfers on a rising clock edge
// where valid && ready are both 1. A producer holding valid keeps its bundle
// stable until it transfers; ready may depend combinationally on the
// consumer's own state but never on the producer's valid.
// ---------------------------------------------------------------------------
interface execute_stage_if #(parameter int DATA_W = exec_pkg::EXEC_DATA_W);
   import exec_pkg::*;

   // upstream (OperationPrep -> execute)
   logic                  inValid;
   logic                  inReady;
   logic [3:0]            aluOp;
   logic [DATA_W-1:0]     readData1;
   logic [DATA_W-1:0]     readData2;
   logic [DATA_W-1:0]     pcOffsetFilled;
   logic [DATA_W-1:0]     pcCurrent;
   logic [DATA_W-1:0]     writeDataToDCache;
   logic [REG_ADDR_W-1:0] writeRegisterIn;
   logic                  regWriteIn;
   logic                  memReadIn;
   logic                  memWriteIn;
   logic                  flush;

   // downstream (execute -> D-cache / writeback)
   logic                  outValid;
   logic                  outReady;
   logic [DATA_W-1:0]     aluResult;
   logic                  zeroFlag;
   logic [DATA_W-1:0]     storeData;
   logic [REG_ADDR_W-1:0] writeRegisterOut;
   logic                  regWriteOut;
   logic                  memReadOut;
   logic                  memWriteOut;
   logic                  branchTaken;
   logic [DATA_W-1:0]     branchTarget;

   // debug view of the control FSM
   exec_state_e           dbgState;

   modport master (
      output inValid, aluOp, readData1, readData2, pcOffsetFilled, pcCurrent,
             writeDataToDCache, writeRegisterIn, regWriteIn, memReadIn,
             memWriteIn, flush, outReady,
      input  inReady, outValid, aluResult, zeroFlag, storeData,
             writeRegisterOut, regWriteOut, memReadOut, memWriteOut,
             branchTaken, branchTarget, dbgState
   );

   modport slave (
      input  inValid, aluOp, readData1, readData2, pcOffsetFilled, pcCurrent,
             writeDataToDCache, writeRegisterIn, regWriteIn, memReadIn,
             memWriteIn, flush, outReady,
      output inReady, outValid, aluResult, zeroFlag, storeData,
             writeRegisterOut, regWriteOut, memReadOut, memWriteOut,
             branchTaken, branchTarget, dbgState
   );

endinterface

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier producing the low DATA_W bits of A*B, one
// multiplier bit per cycle over DATA_W cycles.
//   clock, resetN : clock / async active-low reset
//   i_start       : load operands and begin (only honoured while idle)
//   i_abort       : drop the operation in progress (priority over all)
//   i_a, i_b      : multiplicand / multiplier
//   o_busy        : operation in progress
//   o_done        : final iteration this cycle; o_product valid this cycle
//   o_product     : product including the final iteration's partial sum
// ---------------------------------------------------------------------------
module seq_multiplier #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_product
);

   logic [DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [DATA_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_busy;

   logic [DATA_W-1:0] w_addend;
   logic [DATA_W-1:0] w_acc_next;
   logic              w_last;

   // The multiplicand shifts left and the multiplier right, so bit 0 of
   // r_mplier always selects whether the current shifted multiplicand adds in.
   assign w_addend   = r_mplier[0] ? r_mcand : '0;
   assign w_acc_next = r_acc + w_addend;
   assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

   assign o_busy    = r_busy;
   assign o_done    = r_busy && w_last && !i_abort;
   // Product is presented combinationally in the final cycle so the caller
   // registers it on the same edge that ends the operation.
   assign o_product = w_acc_next;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (i_abort) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// Execute stage of the pipeline: combinational ALU and branch resolution for
// single-cycle ops (latency 1, throughput 1), sequential multiplier for MUL,
// registered result/control bundle towards the D-cache/writeback stage.
//   clock  : all state on posedge
//   resetN : asynchronous active-low reset
//   bus    : execute_stage_if.slave - operand handshake in, result handshake
//            out, synchronous flush, FSM state for debug
// ---------------------------------------------------------------------------
module execute_stage #(
   parameter int DATA_W  = exec_pkg::EXEC_DATA_W,
   parameter int SHAMT_W = exec_pkg::EXEC_SHAMT_W
) (
   input  logic                 clock,
   input  logic                 resetN,
   execute_stage_if.slave       bus
);
   import exec_pkg::*;

   exec_state_e       r_state;
   exec_state_e       w_next_state;

   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_alu_result;
   logic              w_branch_taken;
   logic [DATA_W-1:0] w_branch_target;
   wb_ctrl_t          w_in_ctrl;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_mul_start;
   logic              w_load_alu;
   logic              w_load_mul;
   logic              w_mul_busy;
   logic              w_mul_done;
   logic [DATA_W-1:0] w_mul_product;

   // output register bank
   logic              r_out_valid;
   logic [DATA_W-1:0] r_alu_result;
   logic              r_zero;
   logic [DATA_W-1:0] r_store_data;
   wb_ctrl_t          r_out_ctrl;
   logic              r_branch_taken;
   logic [DATA_W-1:0] r_branch_target;

   // bundle side-data held while the multiplier runs
   wb_ctrl_t          r_pend_ctrl;
   logic [DATA_W-1:0] r_pend_store;
   logic [DATA_W-1:0] r_pend_target;

   assign w_a = bus.readData1;
   assign w_b = bus.readData2;

   assign w_in_ctrl.write_reg = bus.writeRegisterIn;
   assign w_in_ctrl.reg_write = bus.regWriteIn;
   assign w_in_ctrl.mem_read  = bus.memReadIn;
   assign w_in_ctrl.mem_write = bus.memWriteIn;

   // Accept only when the output slot is free or being drained this cycle.
   // resetN gates it so the stage never advertises ready while held in reset.
   assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.outReady)
                       && !bus.flush && resetN;
   assign w_accept   = bus.inValid && w_in_ready;

   // -------------------------------------------------------------------
   // Combinational ALU and branch decision
   // -------------------------------------------------------------------
   always_comb begin
      w_alu_result   = '0;
      w_branch_taken = 1'b0;
      case (bus.aluOp)
         OP_AND:   w_alu_result = w_a & w_b;
         OP_ORR:   w_alu_result = w_a | w_b;
         OP_ADD:   w_alu_result = w_a + w_b;
         OP_SUB:   w_alu_result = w_a - w_b;
         OP_PASSB: w_alu_result = w_b;
         OP_LSL:   w_alu_result = w_a << w_b[SHAMT_W-1:0];
         OP_LSR:   w_alu_result = w_a >> w_b[SHAMT_W-1:0];
         OP_CBZ: begin
            w_alu_result   = w_a;
            w_branch_taken = (w_a == '0);
         end
         OP_CBNZ: begin
            w_alu_result   = w_a;
            w_branch_taken = (w_a != '0);
         end
         OP_B:     w_branch_taken = 1'b1;
         default:  w_alu_result = '0;  // MUL goes through the multiplier
      endcase
   end

   // Offset is in words; the target wraps modulo 2^DATA_W.
   assign w_branch_target = bus.pcCurrent + (bus.pcOffsetFilled << 2);

   // -------------------------------------------------------------------
   // Multiplier
   // -------------------------------------------------------------------
   seq_multiplier #(
      .DATA_W (DATA_W),
      .CNT_W  (SHAMT_W)
   ) u_mul (
      .clock     (clock),
      .resetN    (resetN),
      .i_start   (w_mul_start),
      .i_abort   (bus.flush),
      .i_a       (w_a),
      .i_b       (w_b),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   // -------------------------------------------------------------------
   // Control FSM
   // -------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_mul_start  = 1'b0;
      w_load_alu   = 1'b0;
      w_load_mul   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (is_mul_op(bus.aluOp)) begin
                  w_mul_start  = 1'b1;
                  w_next_state = S_MUL_BUSY;
               end else begin
                  w_load_alu = 1'b1;
               end
            end
         end
         S_MUL_BUSY: begin
            if (w_mul_done) begin
               w_load_mul   = 1'b1;
               w_next_state = S_IDLE;
            end else if (!w_mul_busy) begin
               // multiplier idle without finishing: never strand the FSM
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
      if (bus.flush) begin
         w_next_state = S_IDLE;
         w_mul_start  = 1'b0;
         w_load_alu   = 1'b0;
         w_load_mul   = 1'b0;
      end
   end

   // -------------------------------------------------------------------
   // Pending side-data for MUL (captured on accept)
   // -------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_pend_ctrl   <= '0;
         r_pend_store  <= '0;
         r_pend_target <= '0;
      end else if (w_mul_start) begin
         r_pend_ctrl   <= w_in_ctrl;
         r_pend_store  <= bus.writeDataToDCache;
         r_pend_target <= w_branch_target;
      end
   end

   // -------------------------------------------------------------------
   // Output register bank. The bundle only reloads when the slot is free,
   // so it stays bit-stable while outValid && !outReady.
   // -------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_out_valid     <= 1'b0;
         r_alu_result    <= '0;
         r_zero          <= 1'b0;
         r_store_data    <= '0;
         r_out_ctrl      <= '0;
         r_branch_taken  <= 1'b0;
         r_branch_target <= '0;
      end else if (bus.flush) begin
         r_out_valid    <= 1'b0;
         r_branch_taken <= 1'b0;
      end else if (w_load_alu) begin
         r_out_valid     <= 1'b1;
         r_alu_result    <= w_alu_result;
         r_zero          <= (w_alu_result == '0);
         r_store_data    <= bus.writeDataToDCache;
         r_out_ctrl      <= w_in_ctrl;
         r_branch_taken  <= w_branch_taken;
         r_branch_target <= w_branch_target;
      end else if (w_load_mul) begin
         r_out_valid     <= 1'b1;
         r_alu_result    <= w_mul_product;
         r_zero          <= (w_mul_product == '0);
         r_store_data    <= r_pend_store;
         r_out_ctrl      <= r_pend_ctrl;
         r_branch_taken  <= 1'b0;
         r_branch_target <= r_pend_target;
      end else if (bus.outReady) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.inReady          = w_in_ready;
   assign bus.outValid         = r_out_valid;
   assign bus.aluResult        = r_alu_result;
   assign bus.zeroFlag         = r_zero;
   assign bus.storeData        = r_store_data;
   assign bus.writeRegisterOut = r_out_ctrl.write_reg;
   assign bus.regWriteOut      = r_out_ctrl.reg_write;
   assign bus.memReadOut       = r_out_ctrl.mem_read;
   assign bus.memWriteOut      = r_out_ctrl.mem_write;
   assign bus.branchTaken      = r_branch_taken;
   assign bus.branchTarget     = r_branch_target;
   assign bus.dbgState         = r_state;

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
// Directed, self-checking bench for execute_stage. Inputs change and outputs
// are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_execute_stage;
   import exec_pkg::*;

   localparam int DW = 32;

   logic clock  = 1'b0;
   logic resetN = 1'b0;
   always #5 clock = ~clock;

   execute_stage_if bus ();

   execute_stage dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   logic [DW-1:0] exp_q [$];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.inValid           = 1'b0;
      bus.aluOp             = OP_AND;
      bus.readData1         = '0;
      bus.readData2         = '0;
      bus.pcOffsetFilled    = '0;
      bus.pcCurrent         = '0;
      bus.writeDataToDCache = '0;
      bus.writeRegisterIn   = '0;
      bus.regWriteIn        = 1'b0;
      bus.memReadIn         = 1'b0;
      bus.memWriteIn        = 1'b0;
      bus.flush             = 1'b0;
      bus.outReady          = 1'b1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
      bus.aluOp     = op;
      bus.readData1 = a;
      bus.readData2 = b;
      bus.inValid   = 1'b1;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      resetN = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++;
      if ({bus.outValid, bus.branchTaken, bus.zeroFlag, bus.regWriteOut,
           bus.memReadOut, bus.memWriteOut} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 000000", {bus.outValid, bus.branchTaken,
                  bus.zeroFlag, bus.regWriteOut, bus.memReadOut, bus.memWriteOut});
      end
      n_cmp++;
      if ({bus.aluResult, bus.storeData, bus.branchTarget, bus.writeRegisterOut} !== '0) begin
         n_fail++;
         $display("FAIL reset_data got %h %h %h %h want all 0", bus.aluResult,
                  bus.storeData, bus.branchTarget, bus.writeRegisterOut);
      end
      n_cmp++;
      if (bus.inReady !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_inready_low got %b want 0", bus.inReady);
      end
      resetN = 1'b1;
      #1;
      n_cmp++;
      if (bus.inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_inready_release got %b want 1", bus.inReady);
      end
      n_cmp++;
      if (bus.dbgState !== S_IDLE) begin
         n_fail++;
         $display("FAIL reset_state got %0d want IDLE", bus.dbgState);
      end
   endtask

   // ------------------------------------------------------------------
   // Back-to-back single-cycle ops with outReady held high.
   task automatic test_alu();
      logic [3:0]    v_op  [12] = '{OP_ADD, OP_SUB, OP_SUB, OP_LSL, OP_LSR, OP_LSR,
                                    OP_AND, OP_ORR, OP_PASSB, 4'b1111, OP_ADD, OP_LSL};
      logic [DW-1:0] v_a   [12] = '{32'd7, 32'd5, 32'd0, 32'd1, 32'h8000_0000,
                                    32'h8000_0000, 32'h0000_F0F0, 32'h0000_F0F0,
                                    32'hDEAD_BEEF, 32'd3, 32'hFFFF_FFFF, 32'd3};
      logic [DW-1:0] v_b   [12] = '{32'd5, 32'd5, 32'd1, 32'd31, 32'd32, 32'd4,
                                    32'h0000_FF00, 32'h0000_0F0F, 32'h0000_1234,
                                    32'd4, 32'd1, 32'h21};
      logic [DW-1:0] v_exp [12] = '{32'd12, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000,
                                    32'h8000_0000, 32'h0800_0000, 32'h0000_F000,
                                    32'h0000_FFFF, 32'h0000_1234, 32'd0, 32'd0, 32'd6};
      logic [DW-1:0] exp_res;
      logic [DW-1:0] exp_wd;
      logic [4:0]    exp_wr;
      logic [2:0]    exp_flags;
      bus.outReady = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(v_op[i], v_a[i], v_b[i]);
         bus.writeDataToDCache = v_a[i] ^ v_b[i];
         bus.writeRegisterIn   = 5'(i + 1);
         bus.regWriteIn        = i[0];
         bus.memReadIn         = i[1];
         bus.memWriteIn        = i[2];
         exp_q.push_back(v_exp[i]);
         n_cmp++;
         if (bus.inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_inready[%0d] got %b want 1", i, bus.inReady);
         end
         step();
         exp_res   = exp_q.pop_front();
         exp_wd    = v_a[i] ^ v_b[i];
         exp_wr    = 5'(i + 1);
         exp_flags = {i[0], i[1], i[2]};
         n_cmp++;
         if ({bus.outValid, bus.aluResult, bus.zeroFlag, bus.branchTaken} !==
             {1'b1, exp_res, (exp_res == '0), 1'b0}) begin
            n_fail++;
            $display("FAIL alu_result[%0d] got v=%b r=%h z=%b bt=%b want v=1 r=%h z=%b bt=0",
                     i, bus.outValid, bus.aluResult, bus.zeroFlag, bus.branchTaken,
                     exp_res, (exp_res == '0));
         end
         n_cmp++;
         if ({bus.storeData, bus.writeRegisterOut, bus.regWriteOut, bus.memReadOut,
              bus.memWriteOut} !== {exp_wd, exp_wr, exp_flags}) begin
            n_fail++;
            $display("FAIL alu_fwd[%0d] got %h %h %b%b%b want %h %h %b", i, bus.storeData,
                     bus.writeRegisterOut, bus.regWriteOut, bus.memReadOut,
                     bus.memWriteOut, exp_wd, exp_wr, exp_flags);
         end
      end
      bus.inValid = 1'b0;
      step();
      n_cmp++;
      if (bus.outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_drain got %b want 0", bus.outValid);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_branch();
      logic [3:0]    v_op  [7] = '{OP_CBZ, OP_CBNZ, OP_CBNZ, OP_CBZ, OP_B, OP_ADD, OP_CBZ};
      logic [DW-1:0] v_a   [7] = '{32'd0, 32'd0, 32'd5, 32'd5, 32'd9, 32'd1, 32'd0};
      logic [DW-1:0] v_b   [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0};
      logic [DW-1:0] v_pc  [7] = '{32'h100, 32'h100, 32'h200, 32'h200, 32'h1000,
                                   32'h10, 32'hFFFF_FFF0};
      logic [DW-1:0] v_off [7] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd3, 32'd3,
                                   32'h10, 32'd1, 32'd8};
      logic          v_tk  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [DW-1:0] v_tgt [7] = '{32'hF0, 32'hF0, 32'h20C, 32'h20C, 32'h1040,
                                   32'h14, 32'h10};
      logic [DW-1:0] v_res [7] = '{32'd0, 32'd0, 32'd5, 32'd5, 32'd0, 32'd3, 32'd0};
      bus.outReady = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(v_op[i], v_a[i], v_b[i]);
         bus.pcCurrent      = v_pc[i];
         bus.pcOffsetFilled = v_off[i];
         step();
         n_cmp++;
         if ({bus.outValid, bus.branchTaken, bus.branchTarget, bus.aluResult} !==
             {1'b1, v_tk[i], v_tgt[i], v_res[i]}) begin
            n_fail++;
            $display("FAIL branch[%0d] got v=%b tk=%b tgt=%h r=%h want v=1 tk=%b tgt=%h r=%h",
                     i, bus.outValid, bus.branchTaken, bus.branchTarget, bus.aluResult,
                     v_tk[i], v_tgt[i], v_res[i]);
         end
      end
      bus.inValid = 1'b0;
      step();
   endtask

   // ------------------------------------------------------------------
   task automatic test_backpressure();
      bus.outReady          = 1'b0;
      bus.writeDataToDCache = 32'hCAFE_0001;
      drive(OP_ADD, 32'd2, 32'd3);
      step();
      n_cmp++;
      if ({bus.outValid, bus.aluResult} !== {1'b1, 32'd5}) begin
         n_fail++;
         $display("FAIL bp_first got v=%b r=%h want v=1 r=5", bus.outValid, bus.aluResult);
      end
      // next bundle offered while the downstream stalls
      drive(OP_SUB, 32'd9, 32'd1);
      bus.writeDataToDCache = 32'hCAFE_0002;
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if ({bus.outValid, bus.aluResult, bus.storeData, bus.inReady} !==
             {1'b1, 32'd5, 32'hCAFE_0001, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold[%0d] got v=%b r=%h sd=%h rdy=%b want v=1 r=5 sd=cafe0001 rdy=0",
                     c, bus.outValid, bus.aluResult, bus.storeData, bus.inReady);
         end
         step();
      end
      bus.outReady = 1'b1;
      #1;
      n_cmp++;
      if (bus.inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_ready got %b want 1", bus.inReady);
      end
      step();
      n_cmp++;
      if ({bus.outValid, bus.aluResult, bus.storeData} !== {1'b1, 32'd8, 32'hCAFE_0002}) begin
         n_fail++;
         $display("FAIL bp_second got v=%b r=%h sd=%h want v=1 r=8 sd=cafe0002",
                  bus.outValid, bus.aluResult, bus.storeData);
      end
      bus.inValid = 1'b0;
      step();
   endtask

   // ------------------------------------------------------------------
   task automatic test_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] exp_p);
      bus.outReady        = 1'b1;
      bus.writeRegisterIn = 5'd9;
      bus.regWriteIn      = 1'b1;
      bus.memReadIn       = 1'b0;
      bus.memWriteIn      = 1'b0;
      drive(OP_MUL, a, b);
      step();
      idle_inputs();
      for (int c = 0; c < 32; c++) begin
         n_cmp++;
         if ({bus.inReady, bus.outValid, bus.dbgState} !== {1'b0, 1'b0, S_MUL_BUSY}) begin
            n_fail++;
            $display("FAIL mul_busy[%0d] got rdy=%b v=%b st=%0d want rdy=0 v=0 st=BUSY",
                     c, bus.inReady, bus.outValid, bus.dbgState);
         end
         step();
      end
      n_cmp++;
      if ({bus.outValid, bus.aluResult, bus.zeroFlag, bus.branchTaken,
           bus.writeRegisterOut, bus.regWriteOut, bus.inReady} !==
          {1'b1, exp_p, (exp_p == '0), 1'b0, 5'd9, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL mul_result a=%h b=%h got v=%b r=%h z=%b wr=%h rw=%b rdy=%b want r=%h",
                  a, b, bus.outValid, bus.aluResult, bus.zeroFlag, bus.writeRegisterOut,
                  bus.regWriteOut, bus.inReady, exp_p);
      end
      step();
      n_cmp++;
      if (bus.outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_consumed got %b want 0", bus.outValid);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_flush();
      int rises;
      bus.outReady = 1'b1;
      drive(OP_MUL, 32'd3, 32'd4);
      step();
      idle_inputs();
      repeat (10) step();
      bus.flush = 1'b1;
      #1;
      n_cmp++;
      if (bus.inReady !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_inready_during got %b want 0", bus.inReady);
      end
      step();
      bus.flush = 1'b0;
      #1;
      n_cmp++;
      if ({bus.outValid, bus.branchTaken, bus.dbgState, bus.inReady} !==
          {1'b0, 1'b0, S_IDLE, 1'b1}) begin
         n_fail++;
         $display("FAIL flush_mul got v=%b bt=%b st=%0d rdy=%b want v=0 bt=0 IDLE rdy=1",
                  bus.outValid, bus.branchTaken, bus.dbgState, bus.inReady);
      end
      rises = 0;
      repeat (40) begin
         step();
         if (bus.outValid === 1'b1) rises++;
      end
      n_cmp++;
      if (rises !== 0) begin
         n_fail++;
         $display("FAIL flush_no_result got %0d valid cycles want 0", rises);
      end
      // flush kills a waiting taken branch
      bus.outReady       = 1'b0;
      bus.pcCurrent      = 32'h40;
      bus.pcOffsetFilled = 32'd1;
      drive(OP_B, 32'd0, 32'd0);
      step();
      n_cmp++;
      if ({bus.outValid, bus.branchTaken, bus.branchTarget} !== {1'b1, 1'b1, 32'h44}) begin
         n_fail++;
         $display("FAIL flush_pre_branch got v=%b bt=%b tgt=%h want v=1 bt=1 tgt=44",
                  bus.outValid, bus.branchTaken, bus.branchTarget);
      end
      bus.inValid = 1'b0;
      bus.flush   = 1'b1;
      step();
      n_cmp++;
      if ({bus.outValid, bus.branchTaken} !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_branch got v=%b bt=%b want 00", bus.outValid, bus.branchTaken);
      end
      // bundle offered during flush is dropped
      bus.outReady = 1'b1;
      drive(OP_ADD, 32'd1, 32'd1);
      step();
      bus.flush   = 1'b0;
      bus.inValid = 1'b0;
      n_cmp++;
      if (bus.outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_drop got v=%b want 0", bus.outValid);
      end
      step();
      n_cmp++;
      if (bus.outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_drop_late got v=%b want 0", bus.outValid);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_mid_mul();
      int rises;
      bus.outReady = 1'b0;
      bus.writeDataToDCache = 32'h1234_5678;
      bus.regWriteIn        = 1'b1;
      drive(OP_ORR, 32'h00F0, 32'h000F);
      step();
      // drain the ORR result and accept MUL in the same cycle
      bus.outReady = 1'b1;
      drive(OP_MUL, 32'h0000_FFFF, 32'h0001_0001);
      step();
      idle_inputs();
      repeat (5) step();
      resetN = 1'b0;
      #1;
      n_cmp++;
      if ({bus.outValid, bus.aluResult, bus.zeroFlag, bus.storeData, bus.regWriteOut,
           bus.branchTaken, bus.inReady} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_mul got v=%b r=%h z=%b sd=%h rw=%b bt=%b rdy=%b want all 0",
                  bus.outValid, bus.aluResult, bus.zeroFlag, bus.storeData,
                  bus.regWriteOut, bus.branchTaken, bus.inReady);
      end
      n_cmp++;
      if (bus.dbgState !== S_IDLE) begin
         n_fail++;
         $display("FAIL rst_mid_mul_state got %0d want IDLE", bus.dbgState);
      end
      repeat (2) step();
      resetN = 1'b1;
      #1;
      n_cmp++;
      if (bus.inReady !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_mul_ready got %b want 1", bus.inReady);
      end
      rises = 0;
      repeat (40) begin
         step();
         if (bus.outValid === 1'b1) rises++;
      end
      n_cmp++;
      if (rises !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_mul_no_result got %0d valid cycles want 0", rises);
      end
   endtask

   // ------------------------------------------------------------------
   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_backpressure();
      test_mul(32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
      test_mul(32'd6, 32'd7, 32'd42);
      test_mul(32'd0, 32'd12345, 32'd0);
      test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
      test_flush();
      test_reset_mid_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
